// File: rtl/muldiv_unit.sv
// RV32M multiply/divide beside the ALU: radix-2 shift-add multiply, restoring divide.
// Latency DATA_WIDTH+2 cycles from the start cycle to done (1 cycle for divide-by-zero/overflow).
// Backpressure: stall is held while an operation is accepted or iterating; start is ignored until IDLE/DONE.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    input  logic                  flush,
    output logic                  stall,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    op_q;
    // hi:lo is the product while multiplying, remainder:quotient while dividing
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic [W-1:0]  opnd;
    logic          neg_main;
    logic          neg_rem;

    logic          accepting;
    logic          a_signed;
    logic          b_signed;
    logic          a_neg;
    logic          b_neg;
    logic          div_zero;
    logic          div_ovf;
    logic          special;
    logic [W-1:0]  mag_a;
    logic [W-1:0]  mag_b;
    logic [W-1:0]  special_res;

    always_comb begin
        accepting = (state == IDLE) || (state == DONE);
        a_signed  = (op == 3'b000) || (op == 3'b001) || (op == 3'b010) ||
                    (op == 3'b100) || (op == 3'b110);
        b_signed  = (op == 3'b000) || (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        a_neg     = a_signed & src_a[W-1];
        b_neg     = b_signed & src_b[W-1];
        mag_a     = a_neg ? -src_a : src_a;
        mag_b     = b_neg ? -src_b : src_b;
        div_zero  = op[2] & (src_b == '0);
        div_ovf   = op[2] & ~op[0] & (src_a == MOST_NEG) & (src_b == '1);
        special   = div_zero | div_ovf;
        if (div_zero) begin
            special_res = op[1] ? src_a : '1;
        end else begin
            special_res = op[1] ? '0 : MOST_NEG;
        end
    end

    logic [W:0]   add_sum;
    logic [W:0]   rem_sh;
    logic         quo_bit;
    logic [W-1:0] rem_next;

    always_comb begin
        add_sum  = lo[0] ? ({1'b0, hi} + {1'b0, opnd}) : {1'b0, hi};
        rem_sh   = {hi, lo[W-1]};
        quo_bit  = (rem_sh >= {1'b0, opnd});
        // when the trial subtract succeeds the difference is below the divisor, so W bits suffice
        rem_next = quo_bit ? (rem_sh[W-1:0] - opnd) : rem_sh[W-1:0];
    end

    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix;
    logic [W-1:0]   rem_fix;
    logic [W-1:0]   fix_res;

    always_comb begin
        prod_fix = neg_main ? -{hi, lo} : {hi, lo};
        quo_fix  = neg_main ? -lo : lo;
        rem_fix  = neg_rem ? -hi : hi;
        if (op_q[2]) begin
            fix_res = op_q[1] ? rem_fix : quo_fix;
        end else begin
            fix_res = (op_q == 3'b000) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
        end
    end

    assign stall = (accepting & start & ~flush) | (state == CALC) | (state == FIX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= '0;
            hi       <= '0;
            lo       <= '0;
            opnd     <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            result   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (!start) begin
                        state <= IDLE;
                    end else if (special) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        result <= special_res;
                    end else begin
                        state    <= CALC;
                        busy     <= 1'b1;
                        op_q     <= op;
                        cnt      <= '0;
                        neg_main <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        hi       <= '0;
                        lo       <= op[2] ? mag_a : mag_b;
                        opnd     <= op[2] ? mag_b : mag_a;
                    end
                end
                CALC: begin
                    cnt <= cnt + CW'(1);
                    if (op_q[2]) begin
                        {hi, lo} <= {rem_next, lo[W-2:0], quo_bit};
                    end else begin
                        {hi, lo} <= {add_sum, lo[W-1:1]};
                    end
                    if (cnt == CW'(W-1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result <= fix_res;
                    state  <= DONE;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table with a result scoreboard, then hand-written
// flush, back-to-back and mid-operation reset sequences.
module tb_muldiv_unit;
    localparam int W = 32;
    localparam int N = 19;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         flush;
    logic [2:0]   op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         stall;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        int           lat;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        int           lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[N];

    muldiv_unit #(.DATA_WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive a start for one cycle and record the expected outcome; returns just after the sampling edge.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input int lat);
        exp_t e;
        e.res = exp;
        e.lat = lat;
        sb.push_back(e);
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        #1;
        chk("stall on start", stall, 1'b1);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic collect(input string name);
        int   cyc;
        exp_t e;
        cyc = 1;
        while (!done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty at completion", name);
            return;
        end
        e = sb.pop_front();
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no done within %0d cycles, expected result %h", name, cyc, e.res);
        end else begin
            chk({name, " result"}, result, e.res);
            chk({name, " latency"}, cyc, e.lat);
            chk({name, " busy with done"}, busy, 1'b0);
        end
        @(posedge clk);
        #1;
        chk({name, " done drops"}, done, 1'b0);
    endtask

    initial begin
        int       cyc;
        int       first;
        bit       seen;
        logic [W-1:0] last_res;

        rst   = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'b000;
        src_a = '0;
        src_b = '0;

        vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
        vecs[1]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
        vecs[2]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 34};
        vecs[3]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
        vecs[4]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34};
        vecs[5]  = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34};
        vecs[6]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34};
        vecs[7]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34};
        vecs[8]  = '{3'b101, 32'd100,       32'd7,         32'd14,        34};
        vecs[9]  = '{3'b111, 32'd100,       32'd7,         32'd2,         34};
        vecs[10] = '{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};
        vecs[11] = '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 34};
        vecs[12] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34};
        vecs[13] = '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[14] = '{3'b110, 32'd5,         32'd0,         32'd5,         1};
        vecs[15] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[16] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        vecs[17] = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34};
        vecs[18] = '{3'b011, 32'h1234_5678, 32'h0001_0000, 32'h0000_1234, 34};
        last_res = 32'h0000_1234;

        #2;
        chk("reset result", result, '0);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset stall", stall, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < N; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
            collect($sformatf("vec%0d", i));
        end

        // flush in the middle of a divide
        op = 3'b100; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("flush busy in calc", busy, 1'b1);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush busy", busy, 1'b0);
        chk("flush stall", stall, 1'b0);
        seen = 1'b0;
        repeat (40) begin
            if (done) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("flush no done", seen, 1'b0);
        chk("flush result kept", result, last_res);

        // start and flush together are not accepted
        op = 3'b000; src_a = 32'd3; src_b = 32'd4; start = 1'b1; flush = 1'b1;
        #1;
        chk("start+flush stall", stall, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        chk("start+flush busy", busy, 1'b0);
        seen = 1'b0;
        repeat (40) begin
            if (done) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("start+flush no done", seen, 1'b0);

        // back-to-back: start held through the first operation, operands changed after acceptance
        op = 3'b000; src_a = 32'd3; src_b = 32'd4; start = 1'b1;
        @(posedge clk);
        #1;
        src_a = 32'd5; src_b = 32'd6;
        cyc = 1;
        while (!done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("b2b first done", done, 1'b1);
        chk("b2b first latency", cyc, 34);
        chk("b2b first result", result, 32'd12);
        chk("b2b stall in done", stall, 1'b1);
        first = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc++;
        chk("b2b done drops", done, 1'b0);
        chk("b2b no idle gap", busy, 1'b1);
        while (!done && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("b2b second done", done, 1'b1);
        chk("b2b spacing", cyc - first, 34);
        chk("b2b second result", result, 32'd30);
        @(posedge clk);
        #1;

        // asynchronous reset in the middle of a multiply
        op = 3'b000; src_a = 32'd9; src_b = 32'd9; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("midrst result", result, '0);
        chk("midrst busy", busy, 1'b0);
        chk("midrst done", done, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            if (done || busy) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("midrst no resume", seen, 1'b0);
        issue(3'b000, 32'd2, 32'd2, 32'd4, 34);
        collect("mul after reset");

        chk("scoreboard drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
